// File: rtl/reg_burst_writer.sv
// Byte-stream to register-block burst writer: header, count, then MSB-first words.
// Each assembled word is presented for exactly one cycle; wr_addr parks otherwise.
module reg_burst_writer #(
  parameter int unsigned           ADDR_WIDTH = 7,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] PARK_ADDR  = 7'h7F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            hi_q, hi_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      wr_addr_q <= PARK_ADDR;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Ready depends on state alone, so there is no path from rx_valid to rx_ready.
  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_IDLE, S_CNT, S_HI, S_LO: rx_ready = 1'b1;
      default:                   rx_ready = 1'b0;
    endcase
  end

  assign accept = rx_valid && rx_ready;

  // Registered outputs are computed from the transition, so they line up with
  // the WRITE/DONE state they accompany rather than lagging it by a cycle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    wr_addr_d = PARK_ADDR;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (rx_data[7]) begin
            err_d = 1'b1;
          end else begin
            addr_d  = ADDR_WIDTH'(rx_data[6:0]);
            state_d = S_CNT;
          end
        end
      end
      S_CNT: begin
        if (accept) begin
          cnt_d = rx_data;
          if (rx_data == 8'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          wr_addr_d = addr_q;
          wr_data_d = DATA_WIDTH'({hi_q, rx_data});
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_HI;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_reg_burst_writer.sv
// Bench for reg_burst_writer: random and directed packets, every output cycle logged
// and checked against writes computed from the packet contents.
module tb_reg_burst_writer;

  localparam int LOGN = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [6:0]  lg_addr [LOGN];
  logic [15:0] lg_data [LOGN];
  logic        lg_busy [LOGN];
  logic        lg_done [LOGN];
  logic        lg_err  [LOGN];
  logic        lg_rdy  [LOGN];

  logic [15:0] pw [16];
  logic [15:0] last_word;

  reg_burst_writer #(
    .ADDR_WIDTH(7),
    .DATA_WIDTH(16),
    .PARK_ADDR (7'h7F)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Entry t holds the outputs as they stand after posedge number t.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      lg_addr[cyc] = wr_addr;
      lg_data[cyc] = wr_data;
      lg_busy[cyc] = busy;
      lg_done[cyc] = done;
      lg_err[cyc]  = err;
      lg_rdy[cyc]  = rx_ready;
    end
  end

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_logged(input int t);
    while (cyc <= t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the posedge index at which the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int maxgap, output int stamp);
    int budget;
    budget = 0;
    stamp  = 0;
    if (maxgap > 0) begin
      int g;
      g = $urandom_range(maxgap, 0);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    forever begin
      @(negedge clk);
      if (rx_ready) begin
        stamp = cyc + 1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        return;
      end
      budget++;
      vectors++;
      assert (budget <= 100) else begin
        miscompares++;
        $error("FAIL handshake_timeout: observed %0d cycles without rx_ready expected <= 100", budget);
        finish_run();
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_pkt(input logic [6:0] a0, input int n, input int maxgap, input bit tput);
    int sh, sc, hs, dst, k;
    int bad_addr, bad_data, ndone, nerr, nidle;
    int lo_st [16];
    logic [15:0] cur;
    send_byte({1'b0, a0}, maxgap, sh);
    send_byte(8'(n), maxgap, sc);
    for (int i = 0; i < n; i++) begin
      send_byte(pw[i][15:8], maxgap, hs);
      send_byte(pw[i][7:0], maxgap, lo_st[i]);
    end
    dst = (n == 0) ? sc : lo_st[n-1] + 1;
    wait_logged(dst + 1);
    for (int i = 0; i < n; i++) begin
      chk("write_addr", 32'(lg_addr[lo_st[i]]), 32'((int'(a0) + i) % 128));
      chk("write_data", 32'(lg_data[lo_st[i]]), 32'(pw[i]));
      chk("rdy_in_write", 32'(lg_rdy[lo_st[i]]), 32'd0);
      if (tput && i > 0) chk("cycles_per_word", 32'(lo_st[i] - lo_st[i-1]), 32'd3);
    end
    cur = last_word;
    k = 0; bad_addr = 0; bad_data = 0; ndone = 0; nerr = 0; nidle = 0;
    for (int t = sh; t <= dst + 1; t++) begin
      if (k < n && t == lo_st[k]) begin
        cur = pw[k];
        k++;
      end else begin
        if (lg_addr[t] !== 7'h7F) bad_addr++;
        if (lg_data[t] !== cur) bad_data++;
      end
      if (lg_done[t] === 1'b1) ndone++;
      if (lg_err[t] !== 1'b0) nerr++;
      if (t <= dst && lg_busy[t] !== 1'b1) nidle++;
    end
    last_word = cur;
    chk("park_outside_write", 32'(bad_addr), 32'd0);
    chk("data_hold", 32'(bad_data), 32'd0);
    chk("done_pulses", 32'(ndone), 32'd1);
    chk("done_cycle", 32'(lg_done[dst]), 32'd1);
    chk("rdy_in_done", 32'(lg_rdy[dst]), 32'd0);
    chk("busy_after_done", 32'(lg_busy[dst+1]), 32'd0);
    chk("busy_while_active", 32'(nidle), 32'd0);
    chk("no_err", 32'(nerr), 32'd0);
  endtask

  task automatic run_err(input logic [6:0] low);
    int s;
    send_byte({1'b1, low}, 0, s);
    wait_logged(s + 2);
    chk("err_pulse", 32'(lg_err[s]), 32'd1);
    chk("err_one_cycle", 32'(lg_err[s+1]), 32'd0);
    chk("err_busy", 32'(lg_busy[s]), 32'd0);
    chk("err_busy_next", 32'(lg_busy[s+1]), 32'd0);
    chk("err_ready", 32'(lg_rdy[s]), 32'd1);
    chk("err_no_write", 32'({lg_addr[s], lg_addr[s+1], lg_addr[s+2]}), 32'({7'h7F, 7'h7F, 7'h7F}));
    chk("err_no_done", 32'(lg_done[s]), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'h7F);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
  endtask

  initial begin
    #40000;
    miscompares++;
    $display("FAIL watchdog: observed time limit reached expected run to complete");
    finish_run();
  end

  initial begin
    int s0, s1, sx, l0, h1, rcyc, bad;
    logic [6:0] a0;
    int n, g;

    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    last_word = 16'h0000;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    pw[0] = 16'h1234; pw[1] = 16'hABCD;
    run_pkt(7'h05, 2, 0, 1'b1);

    pw[0] = 16'h0001; pw[1] = 16'h0002;
    run_pkt(7'h7F, 2, 0, 1'b1);

    run_err(7'h05);
    pw[0] = 16'hBEEF;
    run_pkt(7'h01, 1, 0, 1'b1);

    run_pkt(7'h10, 0, 0, 1'b0);

    for (int i = 0; i < 4; i++) pw[i] = 16'($urandom);
    run_pkt(7'($urandom), 4, 3, 1'b0);

    // Reset after the high byte of the second word.
    a0 = 7'($urandom);
    pw[0] = 16'($urandom) | 16'h0100;
    pw[1] = 16'($urandom);
    send_byte({1'b0, a0}, 0, s0);
    send_byte(8'd3, 0, s1);
    send_byte(pw[0][15:8], 0, sx);
    send_byte(pw[0][7:0], 0, l0);
    send_byte(pw[1][15:8], 0, h1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    rcyc = cyc;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    wait_logged(rcyc + 1);
    chk("pre_reset_addr", 32'(lg_addr[l0]), 32'(a0));
    chk("pre_reset_data", 32'(lg_data[l0]), 32'(pw[0]));
    bad = 0;
    for (int t = l0 + 1; t <= rcyc + 1; t++) if (lg_addr[t] !== 7'h7F) bad++;
    chk("no_partial_write", 32'(bad), 32'd0);
    last_word = 16'h0000;
    pw[0] = 16'h5A5A; pw[1] = 16'hC3C3;
    run_pkt(7'h22, 2, 0, 1'b1);

    for (int p = 0; p < 20; p++) begin
      if ($urandom_range(4, 0) == 0) run_err(7'($urandom));
      n  = $urandom_range(5, 0);
      g  = $urandom_range(3, 0);
      a0 = 7'($urandom);
      for (int i = 0; i < n; i++) pw[i] = 16'($urandom);
      run_pkt(a0, n, g, g == 0);
    end

    finish_run();
  end

endmodule
